// File: rtl/arp_cache_aging.sv
// Direct-mapped IP->MAC cache with hashed index, per-entry aging sweep,
// auto-clear after reset and occupancy count. One store access per cycle.
module arp_cache_aging #(
    parameter int CACHE_ADDR_WIDTH = 9,
    parameter int AGE_WIDTH        = 8,
    parameter int AGE_TICK_CYCLES  = 125000000,
    parameter int ENTRY_LIFETIME   = 240
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        query_request_valid,
    output logic                        query_request_ready,
    input  logic [31:0]                 query_request_ip,
    output logic                        query_response_valid,
    input  logic                        query_response_ready,
    output logic                        query_response_error,
    output logic [47:0]                 query_response_mac,
    input  logic                        write_request_valid,
    output logic                        write_request_ready,
    input  logic [31:0]                 write_request_ip,
    input  logic [47:0]                 write_request_mac,
    input  logic                        clear_cache,
    output logic                        cache_busy,
    output logic [CACHE_ADDR_WIDTH:0]   stat_entries
);

    localparam int DEPTH = 1 << CACHE_ADDR_WIDTH;
    localparam int TW    = $clog2(AGE_TICK_CYCLES);
    localparam logic [TW-1:0]         TICK_LAST = TW'(AGE_TICK_CYCLES - 1);
    localparam logic [AGE_WIDTH:0]    LIFETIME  = (AGE_WIDTH + 1)'(ENTRY_LIFETIME);
    localparam logic [CACHE_ADDR_WIDTH:0] STAT_ONE = (CACHE_ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_RUN} state_t;
    state_t state, state_next;

    logic                   entry_valid [DEPTH];
    logic [31:0]            entry_ip    [DEPTH];
    logic [47:0]            entry_mac   [DEPTH];
    logic [AGE_WIDTH-1:0]   entry_age   [DEPTH];

    logic [CACHE_ADDR_WIDTH-1:0] clr_idx, sweep_idx, wr_idx, qry_idx;
    logic [TW-1:0]               tick_cnt;
    logic                        tick_pending, tick_held;
    logic                        run, wr_fire, qry_fire, tick_now;
    logic                        sweep_fire, sweep_last, sweep_expire;
    logic [AGE_WIDTH:0]          age_next;

    function automatic logic [CACHE_ADDR_WIDTH-1:0] hash_idx(input logic [31:0] ip);
        return CACHE_ADDR_WIDTH'(ip ^ (ip >> 16));
    endfunction

    always_comb begin
        run                 = (state == ST_RUN);
        write_request_ready = run;
        query_request_ready = run && !write_request_valid && !query_response_valid;
        cache_busy          = (state == ST_CLEAR);
        wr_idx              = hash_idx(write_request_ip);
        qry_idx             = hash_idx(query_request_ip);
        wr_fire             = write_request_valid && write_request_ready;
        qry_fire            = query_request_valid && query_request_ready;
        tick_now            = run && (tick_cnt == TICK_LAST);
        sweep_fire          = run && !clear_cache && tick_pending && !wr_fire && !qry_fire;
        sweep_last          = (sweep_idx == '1);
        age_next            = {1'b0, entry_age[sweep_idx]} + (AGE_WIDTH + 1)'(1);
        sweep_expire        = entry_valid[sweep_idx] && (age_next >= LIFETIME);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RESET: state_next = ST_CLEAR;
            ST_CLEAR: if (clr_idx == '1) state_next = ST_RUN;
            ST_RUN:   state_next = ST_RUN;
            default:  state_next = ST_CLEAR;
        endcase
        if (clear_cache) state_next = ST_CLEAR;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_RESET;
            clr_idx <= '0;
        end else begin
            state <= state_next;
            if (clear_cache)
                clr_idx <= '0;
            else if (state == ST_CLEAR)
                clr_idx <= clr_idx + CACHE_ADDR_WIDTH'(1);
        end
    end

    // Entry store is deliberately unreset; the CLEAR walk establishes valid bits.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            entry_valid[clr_idx] <= 1'b0;
        end else if (wr_fire && !clear_cache) begin
            entry_valid[wr_idx] <= 1'b1;
            entry_ip[wr_idx]    <= write_request_ip;
            entry_mac[wr_idx]   <= write_request_mac;
            entry_age[wr_idx]   <= '0;
        end else if (sweep_fire && entry_valid[sweep_idx]) begin
            if (sweep_expire)
                entry_valid[sweep_idx] <= 1'b0;
            else
                entry_age[sweep_idx] <= age_next[AGE_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            query_response_valid <= 1'b0;
            query_response_error <= 1'b0;
            query_response_mac   <= '0;
        end else if (qry_fire) begin
            query_response_valid <= 1'b1;
            if (entry_valid[qry_idx] && entry_ip[qry_idx] == query_request_ip) begin
                query_response_error <= 1'b0;
                query_response_mac   <= entry_mac[qry_idx];
            end else begin
                query_response_error <= 1'b1;
                query_response_mac   <= '0;
            end
        end else if (query_response_valid && query_response_ready) begin
            query_response_valid <= 1'b0;
        end
    end

    // A tick landing while a sweep is active is parked in tick_held (max one).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt     <= '0;
            tick_pending <= 1'b0;
            tick_held    <= 1'b0;
            sweep_idx    <= '0;
        end else if (clear_cache || !run) begin
            tick_cnt     <= '0;
            tick_pending <= 1'b0;
            tick_held    <= 1'b0;
            sweep_idx    <= '0;
        end else begin
            tick_cnt <= tick_now ? '0 : tick_cnt + TW'(1);
            if (sweep_fire)
                sweep_idx <= sweep_idx + CACHE_ADDR_WIDTH'(1);
            if (sweep_fire && sweep_last) begin
                tick_pending <= tick_held || tick_now;
                tick_held    <= 1'b0;
            end else if (tick_now) begin
                if (tick_pending)
                    tick_held <= 1'b1;
                else
                    tick_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stat_entries <= '0;
        else if (clear_cache || !run)
            stat_entries <= '0;
        else if (wr_fire && !entry_valid[wr_idx])
            stat_entries <= stat_entries + STAT_ONE;
        else if (sweep_fire && sweep_expire)
            stat_entries <= stat_entries - STAT_ONE;
    end

endmodule

// File: tb/tb_arp_cache_aging.sv
// Bench for arp_cache_aging: directed scenarios plus random traffic, all
// outputs compared every cycle against an array-based reference model.
module tb_arp_cache_aging;

    localparam int CAW = 2;
    localparam int N   = 4;
    localparam int T   = 16;
    localparam int L   = 3;

    logic        clk, rst;
    logic        qv, rr, wv, clr;
    logic [31:0] qip, wip;
    logic [47:0] wmac;
    logic        query_request_ready, query_response_valid, query_response_error;
    logic [47:0] query_response_mac;
    logic        write_request_ready, cache_busy;
    logic [CAW:0] stat_entries;

    arp_cache_aging #(
        .CACHE_ADDR_WIDTH(CAW),
        .AGE_WIDTH(8),
        .AGE_TICK_CYCLES(T),
        .ENTRY_LIFETIME(L)
    ) dut (
        .clk(clk),
        .rst(rst),
        .query_request_valid(qv),
        .query_request_ready(query_request_ready),
        .query_request_ip(qip),
        .query_response_valid(query_response_valid),
        .query_response_ready(rr),
        .query_response_error(query_response_error),
        .query_response_mac(query_response_mac),
        .write_request_valid(wv),
        .write_request_ready(write_request_ready),
        .write_request_ip(wip),
        .write_request_mac(wmac),
        .clear_cache(clr),
        .cache_busy(cache_busy),
        .stat_entries(stat_entries)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain arrays updated once per clock from the rules.
    bit          m_valid [N];
    logic [31:0] m_ip    [N];
    logic [47:0] m_mac   [N];
    int          m_age   [N];
    int          m_phase, m_clr_left, m_run_cycles, m_sweep_pos, m_sweeps_done;
    bit          m_pend, m_held, m_resp_v, m_resp_err, m_qfire, m_wfire;
    logic [47:0] m_resp_mac;

    function automatic int idx_of(input logic [31:0] ip);
        return int'((ip ^ (ip >> 16)) % 32'(N));
    endfunction

    function automatic int count_valid();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    task automatic model_edge();
        bit run, wfire, qfire, tick, swept, finish, hit;
        int i;
        run   = (m_phase == 2);
        wfire = run && wv;
        qfire = run && qv && !wv && !m_resp_v;
        m_qfire = qfire;
        m_wfire = wfire && !clr;
        if (m_resp_v && rr) m_resp_v = 0;
        if (qfire) begin
            i          = idx_of(qip);
            hit        = m_valid[i] && (m_ip[i] == qip);
            m_resp_v   = 1;
            m_resp_err = !hit;
            m_resp_mac = hit ? m_mac[i] : 48'h0;
        end
        if (m_phase == 0 || clr) begin
            m_phase = 1;
            m_clr_left = N;
            for (int k = 0; k < N; k++) m_valid[k] = 0;
            m_pend = 0;
            m_held = 0;
            m_sweep_pos = 0;
            return;
        end
        if (m_phase == 1) begin
            m_clr_left--;
            if (m_clr_left == 0) begin
                m_phase = 2;
                m_run_cycles = 0;
            end
            return;
        end
        tick = (m_run_cycles % T) == T - 1;
        m_run_cycles++;
        swept = m_pend && !wfire && !qfire;
        finish = 0;
        if (wfire) begin
            i = idx_of(wip);
            m_valid[i] = 1;
            m_ip[i]    = wip;
            m_mac[i]   = wmac;
            m_age[i]   = 0;
        end
        if (swept) begin
            if (m_valid[m_sweep_pos]) begin
                if (m_age[m_sweep_pos] + 1 >= L) m_valid[m_sweep_pos] = 0;
                else m_age[m_sweep_pos]++;
            end
            finish = (m_sweep_pos == N - 1);
            m_sweep_pos = finish ? 0 : m_sweep_pos + 1;
        end
        if (finish) begin
            m_sweeps_done++;
            m_pend = m_held || tick;
            m_held = 0;
        end else if (tick) begin
            if (m_pend) m_held = 1;
            else m_pend = 1;
        end
    endtask

    // One clock: readys checked before the edge, registered outputs after it.
    task automatic cycle();
        #1;
        check("wready", 64'(write_request_ready), 64'(m_phase == 2));
        check("qready", 64'(query_request_ready), 64'(m_phase == 2 && !wv && !m_resp_v));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("busy", 64'(cache_busy), 64'(m_phase == 1));
        check("stat", 64'(stat_entries), 64'(count_valid()));
        check("resp_valid", 64'(query_response_valid), 64'(m_resp_v));
        if (m_resp_v) begin
            check("resp_err", 64'(query_response_error), 64'(m_resp_err));
            check("resp_mac", 64'(query_response_mac), 64'(m_resp_mac));
        end
    endtask

    task automatic idle(input int n);
        wv = 0; qv = 0; clr = 0; rr = 1;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_write(input logic [31:0] ip, input logic [47:0] mac);
        bit done = 0;
        wip = ip; wmac = mac; wv = 1;
        for (int k = 0; k < 40 && !done; k++) begin
            cycle();
            done = m_wfire;
        end
        wv = 0;
        if (!done) check("write_timeout", 64'(0), 64'(1));
    endtask

    task automatic do_query(input logic [31:0] ip, output logic err, output logic [47:0] mac);
        bit done = 0;
        qip = ip; qv = 1; rr = 1;
        for (int k = 0; k < 40 && !done; k++) begin
            cycle();
            done = m_qfire;
        end
        qv = 0;
        if (!done) check("query_timeout", 64'(0), 64'(1));
        err = query_response_error;
        mac = query_response_mac;
    endtask

    task automatic wait_sweeps(input int target);
        for (int k = 0; k < 400 && m_sweeps_done < target; k++) cycle();
        if (m_sweeps_done < target) check("sweep_timeout", 64'(m_sweeps_done), 64'(target));
    endtask

    function automatic int count_busy_start();
        return 0;
    endfunction

    localparam logic [31:0] IP1 = 32'h0A000001;
    localparam logic [31:0] IP2 = 32'h0A000002;
    localparam logic [31:0] IP3 = 32'h0A000003;
    localparam logic [31:0] IP5 = 32'h0A000005;
    localparam logic [31:0] IP9 = 32'h0A000009;
    localparam logic [47:0] MAC1 = 48'h020000000001;
    localparam logic [47:0] MAC2 = 48'h020000000002;
    localparam logic [47:0] MAC5 = 48'h020000000005;
    localparam logic [47:0] MAC9 = 48'h020000000009;

    initial begin
        logic        e;
        logic [47:0] m;
        int          n, base;

        rst = 0; qv = 0; rr = 1; wv = 0; clr = 0;
        qip = '0; wip = '0; wmac = '0;
        m_phase = 0; m_clr_left = 0; m_run_cycles = 0; m_sweep_pos = 0; m_sweeps_done = 0;
        m_pend = 0; m_held = 0; m_resp_v = 0; m_resp_err = 0; m_resp_mac = '0;
        m_qfire = 0; m_wfire = 0;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_ip[i] = '0; m_mac[i] = '0; m_age[i] = 0;
        end

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(cache_busy), 64'(0));
        check("rst_stat", 64'(stat_entries), 64'(0));
        check("rst_resp_valid", 64'(query_response_valid), 64'(0));
        check("rst_resp_mac", 64'(query_response_mac), 64'(0));
        check("rst_wready", 64'(write_request_ready), 64'(0));
        check("rst_qready", 64'(query_request_ready), 64'(0));
        rst = 1;

        cycle();
        n = 0;
        while (cache_busy && n < 20) begin
            n++;
            cycle();
        end
        check("init_busy_cycles", 64'(n), 64'(4));
        do_query(IP1, e, m);
        check("init_miss_err", 64'(e), 64'(1));
        check("init_miss_mac", 64'(m), 64'(0));
        check("init_stat", 64'(stat_entries), 64'(0));

        do_write(IP1, MAC1);
        do_query(IP1, e, m);
        check("hit_err", 64'(e), 64'(0));
        check("hit_mac", 64'(m), 64'(MAC1));
        check("hit_stat", 64'(stat_entries), 64'(1));

        do_write(IP5, MAC5);
        do_query(IP1, e, m);
        check("coll_old_err", 64'(e), 64'(1));
        do_query(IP5, e, m);
        check("coll_new_err", 64'(e), 64'(0));
        check("coll_new_mac", 64'(m), 64'(MAC5));
        check("coll_stat", 64'(stat_entries), 64'(1));

        idle(1);
        for (int k = 0; k < 100 && m_pend; k++) cycle();
        do_write(IP2, MAC2);
        base = m_sweeps_done;
        idle(1);
        wait_sweeps(base + 2);
        do_query(IP2, e, m);
        check("age2_hit_err", 64'(e), 64'(0));
        wait_sweeps(base + 3);
        do_query(IP2, e, m);
        check("age3_miss_err", 64'(e), 64'(1));
        check("age3_stat", 64'(stat_entries), 64'(0));

        do_write(IP2, MAC2);
        for (int r = 0; r < 4; r++) begin
            wait_sweeps(m_sweeps_done + 1);
            do_write(IP2, MAC2);
        end
        do_query(IP2, e, m);
        check("refresh_hit_err", 64'(e), 64'(0));
        check("refresh_hit_mac", 64'(m), 64'(MAC2));

        idle(1);
        qip = IP2; qv = 1; rr = 0;
        for (int k = 0; k < 40 && !m_qfire; k++) cycle();
        for (int k = 0; k < 5; k++) begin
            check("bp_qready", 64'(query_request_ready), 64'(0));
            check("bp_resp_valid", 64'(query_response_valid), 64'(1));
            check("bp_resp_mac", 64'(query_response_mac), 64'(MAC2));
            cycle();
        end
        qv = 0; rr = 1;
        cycle();
        cycle();
        check("bp_released", 64'(query_response_valid), 64'(0));

        wip = IP9; wmac = MAC9; wv = 1; qip = IP9; qv = 1;
        #1;
        check("prio_wready", 64'(write_request_ready), 64'(1));
        check("prio_qready_blocked", 64'(query_request_ready), 64'(0));
        cycle();
        wv = 0;
        #1;
        check("prio_qready_next", 64'(query_request_ready), 64'(1));
        cycle();
        qv = 0;
        check("prio_resp_mac", 64'(query_response_mac), 64'(MAC9));

        idle(1);
        do_write(IP1, MAC1);
        do_write(IP2, MAC2);
        do_write(IP3, MAC1);
        for (int k = 0; k < 200 && !(m_pend && m_sweep_pos == 2); k++) cycle();
        check("clr_sweep_seen", 64'(m_pend && m_sweep_pos == 2), 64'(1));
        clr = 1;
        cycle();
        clr = 0;
        n = 0;
        while (cache_busy && n < 20) begin
            n++;
            cycle();
        end
        check("clr_busy_cycles", 64'(n), 64'(4));
        check("clr_stat", 64'(stat_entries), 64'(0));
        do_query(IP1, e, m);
        check("clr_miss1", 64'(e), 64'(1));
        do_query(IP2, e, m);
        check("clr_miss2", 64'(e), 64'(1));
        do_query(IP3, e, m);
        check("clr_miss3", 64'(e), 64'(1));
        idle(20);

        for (int k = 0; k < 2000; k++) begin
            wv   = ($urandom_range(0, 3) == 0);
            wip  = 32'h0A000000 | 32'($urandom_range(0, 11));
            wmac = 48'({$urandom(), $urandom()});
            qv   = ($urandom_range(0, 1) == 0);
            qip  = 32'h0A000000 | 32'($urandom_range(0, 11));
            rr   = ($urandom_range(0, 9) < 7);
            clr  = ($urandom_range(0, 299) == 0);
            cycle();
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/arp_cache_aging.md
Name: arp_cache_aging

Overview:
- Parametrised successor to the team's ARP cache: a direct-mapped IP→MAC table with per-entry aging.
- Stale entries are invalidated automatically, so the ARP engine re-resolves hosts.
- Sits between the ARP engine's query/write requests and a single-port entry store.
- Adds a hashed index, configurable lifetime, a background aging sweep, auto-initialisation after reset, and an occupancy count.

Parameters:
CACHE_ADDR_WIDTH, 9, log2 of entry count; legal range 1..16
AGE_WIDTH, 8, width of the per-entry age field
AGE_TICK_CYCLES, 125000000, clk cycles per age tick; must be ≥ 2^CACHE_ADDR_WIDTH+2
ENTRY_LIFETIME, 240, age in ticks at which an entry is invalidated; 1..2^AGE_WIDTH-1

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
query_request_valid  in  1  lookup request valid
query_request_ready  out  1  lookup request accepted
query_request_ip  in  32  IP to look up
query_response_valid  out  1  lookup result valid
query_response_ready  in  1  lookup result consumed
query_response_error  out  1  1 = miss
query_response_mac  out  48  MAC on hit, 0 on miss
write_request_valid  in  1  insert/update request valid
write_request_ready  out  1  insert accepted
write_request_ip  in  32  IP to store
write_request_mac  in  48  MAC to store
clear_cache  in  1  pulse: invalidate all entries
cache_busy  out  1  high during init/clear
stat_entries  out  CACHE_ADDR_WIDTH+1  number of valid entries

Behaviour:
- Reset (rst low): all outputs 0, tick counter 0, stat_entries 0, sweep idle.
- On release of reset, the FSM enters CLEAR. The entry valid bits are not assumed reset.
- Index: low CACHE_ADDR_WIDTH bits of (ip ^ (ip >> 16)).
- Entry fields: valid, ip[31:0], mac[47:0], age[AGE_WIDTH-1:0].
- The store has one access per cycle. Arbitration priority: CLEAR > write > query > sweep.

FSM states:
- CLEAR:
  - Writes valid=0 to index 0..2^CAW-1, one per cycle.
  - cache_busy=1; both request readys are 0.
  - stat_entries is forced to 0.
  - Goes to RUN after the last index.
- RUN: normal operation.
  - clear_cache=1 in any state re-enters CLEAR at index 0. This aborts any sweep and drops the pending tick.
  - An outstanding query response is still held until consumed.

Write path:
- write_request_ready = (state==RUN).
- On handshake, the indexed entry becomes valid with the given ip and mac, and age=0.
- stat_entries increments by 1 only if the slot was invalid; a collision overwrites silently.

Query path:
- query_request_ready = (state==RUN) && !write_request_valid && !query_response_valid.
- Response is asserted the cycle after the handshake:
  - Hit (valid && ip match): error=0, mac=stored mac.
  - Otherwise: error=1, mac=0.
- Response is held stable until query_response_ready; it deasserts the cycle after consumption.
- A query hit does not reset the entry's age.

Aging:
- The tick counter runs in RUN, wraps at AGE_TICK_CYCLES-1, and raises tick_pending.
- With tick_pending set, the sweep walks indices 0..2^CAW-1, one entry per cycle when the port is free; it stalls on write or query cycles.
- Per valid entry: age_new = age+1.
  - If age_new ≥ ENTRY_LIFETIME: valid=0 and stat_entries decrements.
  - Otherwise the age is stored.
- tick_pending clears when the sweep finishes. A tick arriving mid-sweep is held as a single pending tick; ticks do not accumulate beyond 1.
- A write to an entry that has not yet been swept this round sets age=0, and the sweep then increments it to 1.

Occupancy:
- stat_entries never wraps, because at most one port access happens per cycle.

Test Plan:
- Bench parameters: CACHE_ADDR_WIDTH=2, AGE_TICK_CYCLES=16, ENTRY_LIFETIME=3.
- Reset init: release rst, no stimulus → cache_busy=1 for exactly 4 cycles, then 0; a query for 10.0.0.1 → error=1, mac=0; stat_entries=0.
- Write then hit: write 10.0.0.1 / 02:00:00:00:00:01 (index 1); query 10.0.0.1 → response the next cycle, error=0, mac=02:00:00:00:00:01; stat_entries=1.
- Collision: write 10.0.0.1, then 10.0.0.5 (both index 1); query 10.0.0.1 → miss; query 10.0.0.5 → hit; stat_entries=1.
- Aging: write 10.0.0.2, no rewrites → still hits after 2 ticks, misses after the 3rd sweep completes; stat_entries returns to 0.
  - Rewriting the entry between ticks keeps it hitting.
- Backpressure and priority:
  - Hold query_response_ready=0 for 5 cycles → the response stays stable and query_request_ready=0 throughout.
  - Assert write and query together → the write is accepted first and the query is accepted the following cycle.
- Clear mid-sweep: assert clear_cache during a sweep with 3 valid entries → 4-cycle busy, stat_entries=0, all queries miss, and no sweep resumes until the next tick.
